// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce.
// Drives one column low at a time, samples the synchronized rows at the end
// of each column dwell, classifies each full scan as NONE / KEY / MULTI and
// debounces presses and releases over DEBOUNCE_SCANS identical scans.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int             DW       = $clog2(SCAN_DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]     DEB      = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, RELEASE_DB} state_t;

    // Hex value printed on the key at (row r, col c).
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'h0;  4'hD: key_map = 4'hF;  4'hE: key_map = 4'hE;  default: key_map = 4'hD;
        endcase
    endfunction

    logic [3:0]    row_s1_q, row_s2_q;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    c_q, c_d;
    logic [1:0]    hit_cnt_q, hit_cnt_d;   // hits so far this scan, saturates at 2
    logic [3:0]    hit_code_q, hit_code_d;
    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    logic       last, scan_done, res_key;
    logic [3:0] col_hits, col_code, merged_code;
    logic [1:0] first_row;
    logic [2:0] n_col, tot;

    assign col       = ~(4'b0001 << c_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

    // Two-flop synchronizer on the asynchronous row inputs.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
        end else begin
            row_s1_q <= row;
            row_s2_q <= row_s1_q;
        end
    end

    // Column dwell timing and per-scan hit accumulation.
    always_comb begin
        last      = (div_q == DIV_LAST);
        scan_done = last && (c_q == 2'd3);
        col_hits  = ~row_s2_q;
        n_col     = 3'(col_hits[0]) + 3'(col_hits[1]) + 3'(col_hits[2]) + 3'(col_hits[3]);
        first_row = col_hits[0] ? 2'd0 : col_hits[1] ? 2'd1 : col_hits[2] ? 2'd2 : 2'd3;
        col_code  = key_map(first_row, c_q);
        tot       = {1'b0, hit_cnt_q} + n_col;
        // With one earlier hit the earlier code stands; otherwise any single hit is in this column.
        merged_code = (hit_cnt_q == 2'd1) ? hit_code_q : col_code;
        res_key   = (tot == 3'd1);

        div_d      = last ? '0 : div_q + 1'b1;
        c_d        = last ? c_q + 2'd1 : c_q;
        hit_cnt_d  = hit_cnt_q;
        hit_code_d = hit_code_q;
        if (scan_done) begin
            hit_cnt_d  = 2'd0;
            hit_code_d = 4'd0;
        end else if (last) begin
            hit_cnt_d  = (tot >= 3'd2) ? 2'd2 : tot[1:0];
            hit_code_d = merged_code;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            div_q      <= '0;
            c_q        <= 2'd0;
            hit_cnt_q  <= 2'd0;
            hit_code_q <= 4'd0;
        end else begin
            div_q      <= div_d;
            c_q        <= c_d;
            hit_cnt_q  <= hit_cnt_d;
            hit_code_q <= hit_code_d;
        end
    end

    // Debounce FSM: evaluated once per completed scan; MULTI falls through as not-a-key.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        if (scan_done) begin
            case (state_q)
                IDLE: if (res_key) begin
                    cand_d = merged_code;
                    cnt_d  = 4'd1;
                    if (DEB == 4'd1) begin
                        state_d     = PRESSED;
                        key_code_d  = merged_code;
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                    end else begin
                        state_d = PRESS_DB;
                    end
                end
                PRESS_DB: if (!res_key) begin
                    state_d = IDLE;
                end else if (merged_code != cand_q) begin
                    cand_d = merged_code;
                    cnt_d  = 4'd1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == DEB) begin
                        state_d     = PRESSED;
                        key_code_d  = cand_q;
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                    end
                end
                PRESSED: if (!(res_key && merged_code == key_code_q)) begin
                    cnt_d = 4'd1;
                    if (DEB == 4'd1) begin
                        state_d    = IDLE;
                        key_held_d = 1'b0;
                    end else begin
                        state_d = RELEASE_DB;
                    end
                end
                default: if (res_key && merged_code == key_code_q) begin
                    state_d = PRESSED;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == DEB) begin
                        state_d    = IDLE;
                        key_held_d = 1'b0;
                    end
                end
            endcase
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            cand_q      <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: table of keypad-state segments, each a whole number of
// scans, plus hand-written reset-abort sequences.
module tb_keypad_scanner;
    localparam int SD   = 8;
    localparam int SCAN = 4 * SD;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] row, col, key_code;
    logic       key_valid, key_held;
    logic [15:0] mask = 16'h0;   // bit r*4+c = key at (row r, col c) pressed

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] mask;
        int          scans;
        int          pulses;
        logic [3:0]  code;
        logic        held;
        logic        held_const;
    } seg_t;

    seg_t segs[19];

    localparam logic [15:0] K1 = 16'h0001, K2 = 16'h0002, KA = 16'h0008, K5 = 16'h0020,
                            K9 = 16'h0400, KD = 16'h8000, KN = 16'h0000;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(3)) dut (
        .clk_100MHz(clk), .reset_n(reset_n), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Passive keypad: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (mask[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Applies one segment starting on a scan boundary (at a negedge).
    task automatic run_seg(input int idx, input seg_t s);
        int p = 0;
        int held_bad = 0;
        int col_bad = 0;
        int valid_nohold = 0;
        mask = s.mask;
        repeat (s.scans * SCAN) begin
            @(posedge clk);
            @(negedge clk);
            if (key_valid) begin
                p++;
                if (!key_held) valid_nohold++;
            end
            if (s.held_const && !key_held) held_bad++;
            if (!(col inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) col_bad++;
        end
        check($sformatf("seg%0d pulses", idx), p, s.pulses);
        check($sformatf("seg%0d key_code", idx), key_code, s.code);
        check($sformatf("seg%0d key_held", idx), key_held, s.held);
        check($sformatf("seg%0d held_with_valid", idx), valid_nohold, 0);
        check($sformatf("seg%0d col_onehot", idx), col_bad, 0);
        if (s.held_const) check($sformatf("seg%0d held_const", idx), held_bad, 0);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, " col"}, col, 4'b1110);
        check({name, " key_code"}, key_code, 0);
        check({name, " key_valid"}, key_valid, 0);
        check({name, " key_held"}, key_held, 0);
    endtask

    // Asserts reset between edges, checks at once, holds it, releases on a negedge.
    task automatic async_reset(input string name);
        int pulses = 0;
        #3 reset_n = 1'b0;
        #1 check_reset_vals({name, " immediate"});
        repeat (20) begin
            @(negedge clk);
            if (key_valid) pulses++;
        end
        check_reset_vals({name, " held"});
        check({name, " pulses_in_reset"}, pulses, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        seg_t s;
        //              mask     scans pulses code  held held_const
        segs[0]  = '{KN,       2, 0, 4'h0, 1'b0, 1'b0};
        segs[1]  = '{K2,       5, 1, 4'h2, 1'b1, 1'b0};  // key 2 accepted
        segs[2]  = '{KN,       3, 0, 4'h2, 1'b0, 1'b0};  // released after 3 NONE scans
        segs[3]  = '{K5,       6, 1, 4'h5, 1'b1, 1'b0};
        segs[4]  = '{KN,       2, 0, 4'h5, 1'b1, 1'b0};  // still held after 2 NONE
        segs[5]  = '{KN,       2, 0, 4'h5, 1'b0, 1'b0};  // drops on the 3rd
        segs[6]  = '{K9,       2, 0, 4'h5, 1'b0, 1'b0};  // bouncing 9
        segs[7]  = '{KN,       1, 0, 4'h5, 1'b0, 1'b0};
        segs[8]  = '{K9,       1, 0, 4'h5, 1'b0, 1'b0};
        segs[9]  = '{KN,       1, 0, 4'h5, 1'b0, 1'b0};
        segs[10] = '{K1 | KD,  5, 0, 4'h5, 1'b0, 1'b0};  // MULTI ignored
        segs[11] = '{K1,       3, 1, 4'h1, 1'b1, 1'b0};  // D released -> 1 after 3 scans
        segs[12] = '{KN,       3, 0, 4'h1, 1'b0, 1'b0};
        segs[13] = '{KA,       4, 1, 4'hA, 1'b1, 1'b0};
        segs[14] = '{KN,       1, 0, 4'hA, 1'b1, 1'b1};  // single NONE glitch
        segs[15] = '{KA,       2, 0, 4'hA, 1'b1, 1'b1};  // back to PRESSED, no pulse
        segs[16] = '{K5,       3, 0, 4'hA, 1'b0, 1'b0};  // other key: release first
        segs[17] = '{K5,       3, 1, 4'h5, 1'b1, 1'b0};  // then debounced from IDLE
        segs[18] = '{KN,       3, 0, 4'h5, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset_n = 1'b1;

        for (int i = 0; i < 19; i++) run_seg(i, segs[i]);

        // Reset while in PRESS_DB (key 2 seen on one completed scan).
        mask = K2;
        repeat (SCAN + SCAN / 2) @(negedge clk);
        async_reset("rst_press_db");

        s = '{K2, 4, 1, 4'h2, 1'b1, 1'b0};
        run_seg(100, s);

        // Reset while PRESSED.
        async_reset("rst_pressed");
        s = '{KN, 2, 0, 4'h0, 1'b0, 1'b0};
        run_seg(101, s);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
